// File: rtl/candy_board_store.sv
// candy_board_store: 8x8 candy board with pseudo-random fill, pairwise swap and random refill.
// Build option CANDY_NO_MATCH_INIT_EN: the initial fill rejects candies that would form a run of three.
module candy_board_store #(
  parameter logic [7:0] SEED       = 8'hA5,
  parameter int         NUM_COLORS = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [2:0] X,
  input  logic [2:0] Y,
  output logic [2:0] ColorXY,
  input  logic [2:0] swapX,
  input  logic [2:0] swapY,
  input  logic       swapFlag,
  input  logic [2:0] rewriteX,
  input  logic [2:0] rewriteY,
  input  logic       randFlag,
  input  logic       LoadEn,
  input  logic [5:0] LoadAddr,
  input  logic [2:0] LoadColor,
  output logic       Ready,
  output logic       Busy
);

  typedef enum logic [1:0] {INIT, IDLE, SWAP_WR, RAND_WR} state_t;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

  state_t     state;
  logic [2:0] cells [64];
  logic [7:0] lfsr;
  logic [5:0] cnt;
  logic [5:0] indexA;
  logic [5:0] indexB;
  logic [5:0] indexR;
  logic [2:0] colA;
  logic [2:0] colB;
  logic [2:0] randColor;
  logic       candAccept;
  logic       readyReg;
  logic       busyReg;

  // Out-of-range LFSR codes fold back onto the first colours.
  assign randColor = (lfsr[2:0] >= 3'(NUM_COLORS)) ? lfsr[2:0] - 3'(NUM_COLORS) : lfsr[2:0];

`ifdef CANDY_NO_MATCH_INIT_EN
  logic [5:0] left1;
  logic [5:0] left2;
  logic [5:0] up1;
  logic [5:0] up2;
  logic       rowRun;
  logic       colRun;

  assign left1  = cnt - 6'd1;
  assign left2  = cnt - 6'd2;
  assign up1    = cnt - 6'd8;
  assign up2    = cnt - 6'd16;
  assign rowRun = (cnt[2:1] != 2'b00) && (cells[left1] == randColor) && (cells[left2] == randColor);
  assign colRun = (cnt[5:4] != 2'b00) && (cells[up1] == randColor) && (cells[up2] == randColor);
  assign candAccept = !(rowRun || colRun);
`else
  assign candAccept = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= INIT;
      cnt      <= 6'd0;
      lfsr     <= SEED_EFF;
      readyReg <= 1'b0;
      busyReg  <= 1'b1;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (state)
        INIT: begin
          if (candAccept) begin
            cells[cnt] <= randColor;
            cnt        <= cnt + 6'd1;
            if (cnt == 6'd63) begin
              state    <= IDLE;
              readyReg <= 1'b1;
              busyReg  <= 1'b0;
            end
          end
        end
        IDLE: begin
          if (LoadEn) begin
            cells[LoadAddr] <= LoadColor;
          end else if (swapFlag) begin
            indexA  <= {Y, X};
            indexB  <= {swapY, swapX};
            colA    <= cells[{Y, X}];
            colB    <= cells[{swapY, swapX}];
            state   <= SWAP_WR;
            busyReg <= 1'b1;
          end else if (randFlag) begin
            indexR  <= {rewriteY, rewriteX};
            state   <= RAND_WR;
            busyReg <= 1'b1;
          end
        end
        SWAP_WR: begin
          // With indexA == indexB both writes carry the same original colour.
          cells[indexA] <= colB;
          cells[indexB] <= colA;
          state         <= IDLE;
          busyReg       <= 1'b0;
        end
        RAND_WR: begin
          cells[indexR] <= randColor;
          state         <= IDLE;
          busyReg       <= 1'b0;
        end
        default: begin
          state   <= INIT;
          cnt     <= 6'd0;
          busyReg <= 1'b1;
        end
      endcase
    end
  end

  assign ColorXY = cells[{Y, X}];
  assign Ready   = readyReg;
  assign Busy    = busyReg;

endmodule

// File: tb/tb_candy_board_store.sv
// Scoreboard bench for candy_board_store: stimulus queues expectations, a negedge monitor checks them.
module tb_candy_board_store;

  localparam logic [7:0] SEED       = 8'hA5;
  localparam int         NUM_COLORS = 6;
  localparam int K_COLOR = 0;
  localparam int K_READY = 1;
  localparam int K_BUSY  = 2;
  localparam int K_RANGE = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [2:0] X = 3'd0;
  logic [2:0] Y = 3'd0;
  logic [2:0] ColorXY;
  logic [2:0] swapX = 3'd0;
  logic [2:0] swapY = 3'd0;
  logic       swapFlag = 1'b0;
  logic [2:0] rewriteX = 3'd0;
  logic [2:0] rewriteY = 3'd0;
  logic       randFlag = 1'b0;
  logic       LoadEn = 1'b0;
  logic [5:0] LoadAddr = 6'd0;
  logic [2:0] LoadColor = 3'd0;
  logic       Ready;
  logic       Busy;

  candy_board_store #(.SEED(SEED), .NUM_COLORS(NUM_COLORS)) dut (
    .Clk(Clk), .Reset(Reset), .X(X), .Y(Y), .ColorXY(ColorXY),
    .swapX(swapX), .swapY(swapY), .swapFlag(swapFlag),
    .rewriteX(rewriteX), .rewriteY(rewriteY), .randFlag(randFlag),
    .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadColor(LoadColor),
    .Ready(Ready), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int    kind;
    int    value;
    string name;
  } exp_t;

  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails = 0;
  int   edgeCount = 0;
  int   model [64];
  int   initImage [64];
  int   initLen;

  // Non-reset edges since the last reset edge: the LFSR state used at the next edge is step^edgeCount(SEED).
  always @(posedge Clk) edgeCount <= Reset ? 0 : edgeCount + 1;

  function automatic logic [7:0] lfsrAt(int n);
    logic [7:0] s;
    s = SEED;
    for (int i = 0; i < n; i++) s = {s[6:0], ^(s & 8'hB8)};
    return s;
  endfunction

  function automatic int mapColor(logic [7:0] s);
    return int'(s & 8'h07) % NUM_COLORS;
  endfunction

  initial begin : monitor
    exp_t e;
    int   act;
    bit   ok;
    forever begin
      @(negedge Clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        case (e.kind)
          K_READY: act = int'(Ready);
          K_BUSY:  act = int'(Busy);
          default: act = int'(ColorXY);
        endcase
        ok = (e.kind == K_RANGE) ? (act < e.value) : (act == e.value);
        nChecks++;
        if (!ok) begin
          nFails++;
          if (e.kind == K_RANGE)
            $display("FAIL %s: got %0d, required below %0d", e.name, act, e.value);
          else
            $display("FAIL %s: got %0d, required %0d", e.name, act, e.value);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expectVal(int kind, int value, string name);
    exp_t e;
    e.kind  = kind;
    e.value = value;
    e.name  = name;
    expQ.push_back(e);
  endtask

  task automatic readCell(int i, string tag);
    X = 3'(i % 8);
    Y = 3'(i / 8);
    expectVal(K_COLOR, model[i], $sformatf("%s cell%0d", tag, i));
    tick();
  endtask

  task automatic sweep(string tag);
    for (int i = 0; i < 64; i++) readCell(i, tag);
  endtask

  // Board and duration of the initial fill, derived from the LFSR sequence and the fill rules.
  task automatic buildInitModel();
    int n;
    int i;
    int c;
    bit rej;
    n = 0;
    i = 0;
    while (i < 64) begin
      c = mapColor(lfsrAt(n));
      n++;
      rej = 1'b0;
`ifdef CANDY_NO_MATCH_INIT_EN
      if (i % 8 >= 2 && initImage[i-1] == c && initImage[i-2] == c) rej = 1'b1;
      if (i / 8 >= 2 && initImage[i-8] == c && initImage[i-16] == c) rej = 1'b1;
`endif
      if (!rej) begin
        initImage[i] = c;
        i++;
      end
    end
    initLen = n;
  endtask

  task automatic runInit(string tag);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int k = 0; k < initLen; k++) begin
      expectVal(K_READY, 0, $sformatf("%s ready_low c%0d", tag, k));
      expectVal(K_BUSY, 1, $sformatf("%s busy_high c%0d", tag, k));
      tick();
    end
    expectVal(K_READY, 1, $sformatf("%s ready_after_init", tag));
    expectVal(K_BUSY, 0, $sformatf("%s busy_after_init", tag));
    for (int i = 0; i < 64; i++) model[i] = initImage[i];
    for (int i = 0; i < 64; i++) begin
      X = 3'(i % 8);
      Y = 3'(i / 8);
      expectVal(K_RANGE, NUM_COLORS, $sformatf("%s range cell%0d", tag, i));
      expectVal(K_COLOR, model[i], $sformatf("%s init cell%0d", tag, i));
      tick();
    end
  endtask

  task automatic doLoad(int addr, int col);
    LoadEn    = 1'b1;
    LoadAddr  = 6'(addr);
    LoadColor = 3'(col);
    tick();
    LoadEn = 1'b0;
    model[addr] = col;
    expectVal(K_BUSY, 0, "load busy_low");
  endtask

  task automatic doSwap(int a, int b);
    int tmp;
    X = 3'(a % 8);
    Y = 3'(a / 8);
    swapX = 3'(b % 8);
    swapY = 3'(b / 8);
    swapFlag = 1'b1;
    expectVal(K_BUSY, 0, "swap busy_before");
    tick();
    swapFlag = 1'b0;
    expectVal(K_BUSY, 1, "swap busy_during");
    tick();
    expectVal(K_BUSY, 0, "swap busy_after");
    tmp = model[a];
    model[a] = model[b];
    model[b] = tmp;
  endtask

  task automatic doRand(int idx);
    int expCol;
    rewriteX = 3'(idx % 8);
    rewriteY = 3'(idx / 8);
    randFlag = 1'b1;
    expCol = mapColor(lfsrAt(edgeCount + 1));
    tick();
    randFlag = 1'b0;
    expectVal(K_BUSY, 1, "rand busy_during");
    tick();
    expectVal(K_BUSY, 0, "rand busy_after");
    model[idx] = expCol;
    X = 3'(idx % 8);
    Y = 3'(idx / 8);
    expectVal(K_RANGE, NUM_COLORS, $sformatf("rand range cell%0d", idx));
    readCell(idx, "rand");
  endtask

  initial begin : stimulus
    int pattern [12];
    int a;
    int b;
    pattern = '{5, 3, 1, 4, 2, 5, 2, 2, 0, 1, 2, 3};
    buildInitModel();
    runInit("init1");

    for (int i = 0; i < 64; i++)
      doLoad(i, (i < 12) ? pattern[i] : int'($urandom_range(0, NUM_COLORS - 1)));
    sweep("load");

    doSwap(0, 1);
    readCell(0, "swap01");
    readCell(1, "swap01");
    doSwap(19, 19);
    sweep("swap_same");

    doRand(63);
    sweep("rand63");
    for (int k = 0; k < 5; k++) doRand(int'($urandom_range(0, 63)));

    // All three requests on one edge: only the load is performed.
    a = int'($urandom_range(0, 63));
    LoadEn = 1'b1;
    LoadAddr = 6'(a);
    LoadColor = 3'((model[a] + 1) % NUM_COLORS);
    X = 3'd0; Y = 3'd0; swapX = 3'd7; swapY = 3'd7; swapFlag = 1'b1;
    rewriteX = 3'd3; rewriteY = 3'd3; randFlag = 1'b1;
    tick();
    model[a] = (model[a] + 1) % NUM_COLORS;
    LoadEn = 1'b0; swapFlag = 1'b0; randFlag = 1'b0;
    expectVal(K_BUSY, 0, "combo busy_low");
    sweep("combo");

    // Requests while busy are dropped.
    X = 3'd0; Y = 3'd0; swapX = 3'd7; swapY = 3'd7; swapFlag = 1'b1;
    tick();
    swapFlag = 1'b1; randFlag = 1'b1; LoadEn = 1'b1;
    LoadAddr = 6'd5; LoadColor = 3'((model[5] + 1) % NUM_COLORS);
    rewriteX = 3'd2; rewriteY = 3'd2;
    X = 3'd4; Y = 3'd4; swapX = 3'd1; swapY = 3'd1;
    expectVal(K_BUSY, 1, "busy_drop busy");
    tick();
    swapFlag = 1'b0; randFlag = 1'b0; LoadEn = 1'b0;
    a = model[0]; model[0] = model[63]; model[63] = a;
    expectVal(K_BUSY, 0, "busy_drop idle");
    sweep("busy_drop");

    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0: doLoad(int'($urandom_range(0, 63)), int'($urandom_range(0, NUM_COLORS - 1)));
        1: begin
          a = int'($urandom_range(0, 63));
          b = int'($urandom_range(0, 63));
          doSwap(a, b);
          readCell(a, "rnd_swapA");
          readCell(b, "rnd_swapB");
        end
        default: doRand(int'($urandom_range(0, 63)));
      endcase
    end
    sweep("random_ops");

    // Reset lands on the SWAP_WR edge.
    X = 3'd1; Y = 3'd0; swapX = 3'd2; swapY = 3'd0; swapFlag = 1'b1;
    tick();
    swapFlag = 1'b0;
    runInit("init2");

    tick();
    @(negedge Clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/candy_board_store.md
Name: candy_board_store

Overview:
- 8x8 board memory sitting directly downstream of the candy game state machine.
- Provides the colour of the cursor cell to the FSM (ColorXY).
- Executes the swap requests (swapFlag) and random-refill requests (randFlag) that the FSM issues.
- Fills the board with pseudo-random candies after reset and gates the FSM through Ready (wired to the FSM's Enable).

Parameters:
- SEED, 8'hA5, LFSR reset value; must be nonzero (0 is forced to 8'h01).
- NUM_COLORS, 6, number of candy colours; legal colour codes are 0..NUM_COLORS-1 (0 blue, 1 red, 2 yellow, 3 purple, 4 green, 5 orange).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- X  in  3  cursor column.
- Y  in  3  cursor row.
- ColorXY  out  3  colour at cell index 8*Y+X; combinational read.
- swapX  in  3  swap partner column.
- swapY  in  3  swap partner row.
- swapFlag  in  1  one-cycle request: swap (X,Y) with (swapX,swapY).
- rewriteX  in  3  refill column.
- rewriteY  in  3  refill row.
- randFlag  in  1  one-cycle request: write a random colour at (rewriteX,rewriteY).
- LoadEn  in  1  direct-write strobe, used by the bench and by a future level loader.
- LoadAddr  in  6  direct-write cell index (8*Y+X).
- LoadColor  in  3  direct-write colour.
- Ready  out  1  high once the initial fill is complete.
- Busy  out  1  high while the block is in any state other than IDLE.

Behaviour:
- Storage: 64 x 3-bit registers. Cell index is 8*Y+X.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Advances every cycle when not in Reset.
  - Random colour = lfsr[2:0]; values 6 and 7 map to 0 and 1.
- Reset (any state, including mid-swap):
  - state <= INIT, init counter <= 0, lfsr <= SEED.
  - Ready <= 0, Busy <= 1.
  - Board contents are don't-care until INIT overwrites them.
- INIT:
  - Writes cell[cnt] <= random colour, then cnt <= cnt+1, one cell per cycle.
  - After cell 63 is written: state <= IDLE, Ready <= 1, Busy <= 0.
  - INIT therefore takes 64 cycles when the optional feature is off.
  - swapFlag, randFlag and LoadEn are ignored in INIT.
- IDLE, priority when several requests are sampled on the same edge: LoadEn > swapFlag > randFlag. Lower-priority requests on that edge are dropped; the FSM re-issues them.
  - LoadEn: cell[LoadAddr] <= LoadColor at that edge. Stays in IDLE.
  - swapFlag:
    - Latch indexA = 8*Y+X and indexB = 8*swapY+swapX.
    - Latch colA = cell[A] and colB = cell[B].
    - state <= SWAP_WR.
  - randFlag: latch index R = 8*rewriteY+rewriteX; state <= RAND_WR.
- SWAP_WR: one cycle. cell[A] <= colB, cell[B] <= colA, state <= IDLE.
  - If A == B the board is unchanged.
  - The write happens at the edge after the request edge; ColorXY shows the new value from the next cycle.
- RAND_WR: one cycle. cell[R] <= random colour at that edge, state <= IDLE.
- Busy = (state != IDLE).
- Requests arriving while Busy are dropped.
- Ready stays 1 until the next Reset.
- ColorXY is a combinational mux of the board registers, valid in every state.

Optional Feature:
- Macro: CANDY_NO_MATCH_INIT_EN.
- Defined:
  - In INIT, a candidate colour is rejected when it equals both cells to its left (same row, x>=2), or both cells above it (y>=2).
  - On rejection the cell is not written and cnt holds. The LFSR advance supplies the next candidate on the next cycle.
  - The board after INIT contains no horizontal or vertical run of 3. INIT takes 64 cycles or more.
  - LoadEn and randFlag writes are not checked.
- Undefined: every candidate is accepted; INIT is exactly 64 cycles.

Test Plan:
- Reset for 1 cycle, then release -> Ready=0, Busy=1 for exactly 64 cycles (macro off), then Ready=1, Busy=0; every ColorXY read over all 64 cells is in 0..5.
- After INIT, LoadEn writes the board to c[0..63] = 5,3,1,4,2,5,2,2,0,1,2,3,... (rows of 8). Sweep X,Y -> ColorXY equals the loaded value at every index.
- With that board, X=0,Y=0, swapX=1,swapY=0, one-cycle swapFlag -> Busy=1 for 1 cycle; then cell0=3, cell1=5. Swap with A==B -> board unchanged.
- randFlag at rewriteX=7,rewriteY=7 -> cell63 changes at the following edge to the mapped lfsr value, which matches a reference LFSR model; value is in 0..5; no other cell changes.
- swapFlag, randFlag and LoadEn in the same cycle -> only the load is performed; Busy stays 0. Flags issued while Busy -> ignored.
- Reset asserted during SWAP_WR -> the next edge is in INIT with Ready=0. With CANDY_NO_MATCH_INIT_EN defined, the board after INIT has no run of 3 in any row or column.
